// File: rtl/mul_issue.sv
// mul_issue: issues M-extension multiply requests from the execute stage to an
// external multiplier. It holds the operands for LATENCY cycles, samples the
// product, and presents a writeback request until the writeback port accepts it.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid_i / req_ready_o request handshake (ready only in IDLE)
//   op1_i, op2_i, func3_i     operands and opcode (000 MUL, 001 MULH,
//                             010 MULHSU, 011 MULHU)
//   rd_i                      destination register index
//   mul_op1_o, mul_op2_o      operands driven to the multiplier
//   mul_func3_o, mul_en_o     multiplier opcode and enable
//   mul_lo_i, mul_hi_i        multiplier product words
//   stall_o                   holds the upstream pipeline (combinational)
//   wb_valid_o, wb_rd_o,
//   wb_data_o / wb_ready_i    writeback handshake
//
// Build option: define MUL_ISSUE_BYPASS_EN to keep a record of the last
// completed multiply. A matching request then skips the multiplier.
module mul_issue #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [2:0]  func3_i,
  input  logic [4:0]  rd_i,
  output logic [31:0] mul_op1_o,
  output logic [31:0] mul_op2_o,
  output logic [2:0]  mul_func3_o,
  output logic        mul_en_o,
  input  logic [31:0] mul_lo_i,
  input  logic [31:0] mul_hi_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  input  logic        wb_ready_i
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, CALC, WB} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         rd_q, rd_d;
  logic [31:0]        mul_op1_d, mul_op2_d;
  logic [2:0]         mul_func3_d;
  logic               mul_en_d, wb_valid_d, req_ready_d;
  logic [4:0]         wb_rd_d;
  logic [31:0]        wb_data_d;
  logic [31:0]        result_c;
  logic               bypass_hit_c;

`ifdef MUL_ISSUE_BYPASS_EN
  logic               rec_valid_q, rec_valid_d;
  logic [31:0]        rec_op1_q, rec_op1_d;
  logic [31:0]        rec_op2_q, rec_op2_d;
  logic [2:0]         rec_func3_q, rec_func3_d;
  logic [31:0]        rec_res_q, rec_res_d;

  // Only real multiplies can hit; func3[2] requests never reach the record.
  assign bypass_hit_c = rec_valid_q && !func3_i[2] && (op1_i == rec_op1_q) &&
                        (op2_i == rec_op2_q) && (func3_i == rec_func3_q);
`else
  assign bypass_hit_c = 1'b0;
`endif

  // Low word for MUL, high word for the three MULH variants.
  assign result_c = (mul_func3_o == 3'b000) ? mul_lo_i : mul_hi_i;

  assign stall_o = (state_q != IDLE) || req_valid_i;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    mul_op1_d   = mul_op1_o;
    mul_op2_d   = mul_op2_o;
    mul_func3_d = mul_func3_o;
    wb_rd_d     = wb_rd_o;
    wb_data_d   = wb_data_o;
`ifdef MUL_ISSUE_BYPASS_EN
    rec_valid_d = rec_valid_q;
    rec_op1_d   = rec_op1_q;
    rec_op2_d   = rec_op2_q;
    rec_func3_d = rec_func3_q;
    rec_res_d   = rec_res_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          rd_d = rd_i;
          if (func3_i[2]) begin
            state_d   = WB;
            wb_rd_d   = rd_i;
            wb_data_d = 32'd0;
          end else if (bypass_hit_c) begin
            state_d   = WB;
            wb_rd_d   = rd_i;
`ifdef MUL_ISSUE_BYPASS_EN
            wb_data_d = (rd_i == 5'd0) ? 32'd0 : rec_res_q;
`endif
          end else begin
            state_d     = CALC;
            cnt_d       = CNT_W'(LATENCY - 1);
            mul_op1_d   = op1_i;
            mul_op2_d   = op2_i;
            mul_func3_d = func3_i;
          end
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          state_d   = WB;
          wb_rd_d   = rd_q;
          wb_data_d = (rd_q == 5'd0) ? 32'd0 : result_c;
`ifdef MUL_ISSUE_BYPASS_EN
          rec_valid_d = 1'b1;
          rec_op1_d   = mul_op1_o;
          rec_op2_d   = mul_op2_o;
          rec_func3_d = mul_func3_o;
          rec_res_d   = result_c;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WB: begin
        if (wb_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    mul_en_d    = (state_d == CALC);
    wb_valid_d  = (state_d == WB);
    req_ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      mul_op1_o   <= '0;
      mul_op2_o   <= '0;
      mul_func3_o <= '0;
      mul_en_o    <= 1'b0;
      wb_valid_o  <= 1'b0;
      wb_rd_o     <= '0;
      wb_data_o   <= '0;
      req_ready_o <= 1'b1;
`ifdef MUL_ISSUE_BYPASS_EN
      rec_valid_q <= 1'b0;
      rec_op1_q   <= '0;
      rec_op2_q   <= '0;
      rec_func3_q <= '0;
      rec_res_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      mul_op1_o   <= mul_op1_d;
      mul_op2_o   <= mul_op2_d;
      mul_func3_o <= mul_func3_d;
      mul_en_o    <= mul_en_d;
      wb_valid_o  <= wb_valid_d;
      wb_rd_o     <= wb_rd_d;
      wb_data_o   <= wb_data_d;
      req_ready_o <= req_ready_d;
`ifdef MUL_ISSUE_BYPASS_EN
      rec_valid_q <= rec_valid_d;
      rec_op1_q   <= rec_op1_d;
      rec_op2_q   <= rec_op2_d;
      rec_func3_q <= rec_func3_d;
      rec_res_q   <= rec_res_d;
`endif
    end
  end

endmodule

// File: tb/tb_mul_issue.sv
// Testbench for mul_issue: transaction-level reference model, a behavioural
// multiplier on the mul_* port, directed cases plus randomized requests.
module tb_mul_issue;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] op1, op2;
  logic [2:0]  func3;
  logic [4:0]  rd;
  logic [31:0] mul_op1, mul_op2;
  logic [2:0]  mul_func3;
  logic        mul_en;
  logic [31:0] mul_lo, mul_hi;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;

  int checks = 0;
  int failures = 0;

  // Reference state: last operands that reached the multiplier, bypass record.
  logic [31:0] last_a, last_b;
  logic [2:0]  last_f3;
  bit          rec_v;
  logic [31:0] rec_a, rec_b;
  logic [2:0]  rec_f3;

  mul_issue #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op1_i(op1), .op2_i(op2), .func3_i(func3), .rd_i(rd),
    .mul_op1_o(mul_op1), .mul_op2_o(mul_op2),
    .mul_func3_o(mul_func3), .mul_en_o(mul_en),
    .mul_lo_i(mul_lo), .mul_hi_i(mul_hi),
    .stall_o(stall),
    .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .wb_ready_i(wb_ready)
  );

  always #5 clk = ~clk;

  // Full 64-bit RISC-V product with signedness chosen by func3.
  function automatic logic [63:0] product(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3);
    logic signed [63:0] xa, xb;
    xa = (f3[1:0] == 2'b11) ? {32'd0, a} : {{32{a[31]}}, a};
    xb = (f3[1:0] == 2'b00 || f3[1:0] == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    return 64'(xa * xb);
  endfunction

  // Multiplier stand-in; an obvious sentinel when not enabled.
  always_comb begin
    logic [63:0] p;
    p = product(mul_op1, mul_op2, mul_func3);
    if (mul_en) begin
      mul_lo = p[31:0];
      mul_hi = p[63:32];
    end else begin
      mul_lo = 32'hDEAD_BEEF;
      mul_hi = 32'hBAAD_F00D;
    end
  end

  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] f3, input logic [4:0] r);
    logic [63:0] p;
    p = product(a, b, f3);
    if (r == 5'd0 || f3[2]) return 32'd0;
    return (f3 == 3'b000) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    last_a = '0; last_b = '0; last_f3 = '0;
    rec_v = 0; rec_a = '0; rec_b = '0; rec_f3 = '0;
  endtask

  // One complete request: issue, wait for writeback, hold off, release.
  task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                        input logic [4:0] r, input int hold);
    bit hit, full, seen;
    int n, en_cnt, exp_lat, exp_en;
    logic [31:0] exp_data;
    hit = 0;
`ifdef MUL_ISSUE_BYPASS_EN
    hit = rec_v && !f3[2] && a == rec_a && b == rec_b && f3 == rec_f3;
`endif
    full = !f3[2] && !hit;
    exp_data = ref_result(a, b, f3, r);
    exp_lat = full ? LAT + 1 : 1;
    exp_en = full ? LAT : 0;

    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; op1 = a; op2 = b; func3 = f3; rd = r;
    #1;
    chk("stall_on_req", 32'(stall), 32'd1);

    n = 0; en_cnt = 0; seen = 0;
    while (!seen && n < 64) begin
      @(negedge clk);
      n++;
      if (mul_en) begin
        en_cnt++;
        chk("mul_op1", mul_op1, a);
        chk("mul_op2", mul_op2, b);
        chk("mul_func3", 32'(mul_func3), 32'(f3));
      end
      if (wb_valid) seen = 1;
      if (n == 1) begin
        req_valid = 1'b0; op1 = $urandom; op2 = $urandom;
        func3 = 3'($urandom); rd = 5'($urandom);
      end
    end
    chk("wb_seen", 32'(seen), 32'd1);
    if (!seen) return;
    chk("wb_latency", 32'(n), 32'(exp_lat));
    chk("mul_en_cycles", 32'(en_cnt), 32'(exp_en));
    chk("wb_data", wb_data, exp_data);
    chk("wb_rd", 32'(wb_rd), 32'(r));
    if (full) begin
      last_a = a; last_b = b; last_f3 = f3;
      rec_v = 1; rec_a = a; rec_b = b; rec_f3 = f3;
    end

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(wb_valid), 32'd1);
      chk("hold_data", wb_data, exp_data);
      chk("hold_rd", 32'(wb_rd), 32'(r));
      chk("hold_stall", 32'(stall), 32'd1);
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_mul_en", 32'(mul_en), 32'd0);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    chk("post_wb_valid", 32'(wb_valid), 32'd0);
    chk("post_ready", 32'(req_ready), 32'd1);
    chk("post_hold_op1", mul_op1, last_a);
    chk("post_hold_op2", mul_op2, last_b);
    chk("post_hold_f3", 32'(mul_func3), 32'(last_f3));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; op1 = '0; op2 = '0; func3 = '0; rd = '0;
    wb_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_mul_op1", mul_op1, 32'd0);
    chk("rst_mul_en", 32'(mul_en), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);

    // Basic MUL, signed/unsigned high words, long writeback hold-off.
    do_req(32'd3, 32'd5, 3'b000, 5'd7, 0);
    do_req(32'hFFFF_FFFF, 32'd2, 3'b001, 5'd9, 0);
    do_req(32'hFFFF_FFFF, 32'd2, 3'b011, 5'd9, 0);
    do_req(32'hFFFF_FFFF, 32'd2, 3'b010, 5'd10, 0);
    do_req(32'h1234_5678, 32'h9ABC_DEF0, 3'b000, 5'd11, 4);
    // Non-multiply func3 and rd 0.
    do_req(32'd3, 32'd5, 3'b101, 5'd4, 1);
    do_req(32'd3, 32'd5, 3'b000, 5'd0, 0);

    // Reset during the second CALC cycle abandons the operation.
    @(negedge clk);
    req_valid = 1'b1; op1 = 32'd3; op2 = 32'd5; func3 = 3'b000; rd = 5'd7;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("mid_rst_wb_data", wb_data, 32'd0);
    chk("mid_rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("mid_rst_op1", mul_op1, 32'd0);
    chk("mid_rst_op2", mul_op2, 32'd0);
    chk("mid_rst_f3", 32'(mul_func3), 32'd0);
    chk("mid_rst_en", 32'(mul_en), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_rst_no_wb", 32'(wb_valid), 32'd0);
    end

    // Repeat of an identical request, then a changed operand.
    do_req(32'd3, 32'd5, 3'b000, 5'd7, 0);
    do_req(32'd3, 32'd5, 3'b000, 5'd7, 0);
    do_req(32'd3, 32'd6, 3'b000, 5'd7, 0);

    // Randomized traffic; occasional repeats exercise the bypass path.
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a, b;
      logic [2:0]  f3;
      logic [4:0]  r;
      if (k % 7 == 3) begin
        a = rec_a; b = rec_b; f3 = rec_f3;
      end else begin
        a = $urandom; b = $urandom;
        if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
        f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      end
      r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      do_req(a, b, f3, r, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
